difftest_commit_queue: RTL and testbench
========================================

// Module: difftest_commit_queue
// PURPOSE
//  Parametrised difftest commit monitor between core commit stage and simulator DPI glue.
//  Keeps a shadow architectural register file updated from up to NCOMMIT commits/cycle.
//  Queues each commit as a sequence-numbered record in a DEPTH-entry FIFO, drained by valid/ready.
//  Flags overflow and, optionally, a no-commit hang.
// PARAMETERS
//  XLEN     64    data/pc width
//  NREGS    33    shadow register entries (entry 0 reads zero)
//  NCOMMIT  2     commit channels per cycle (1..4)
//  DEPTH    8     FIFO entries, power of two, >= NCOMMIT
//  TIMEOUT  4096  watchdog limit in cycles (used only with DIFFTEST_WATCHDOG_EN)
//  Derived: AW=$clog2(NREGS)
// PORTS
//  clock        in   1             clock, all state on posedge
//  reset_n      in   1             asynchronous active-low reset
//  cm_valid     in   NCOMMIT       per-channel commit strobe
//  cm_pc        in   NCOMMIT*XLEN  committed pc, channel i at [i*XLEN+:XLEN]
//  cm_inst      in   NCOMMIT*32    committed instruction
//  cm_wen       in   NCOMMIT       register write enable
//  cm_wdest     in   NCOMMIT*AW    destination index
//  cm_wdata     in   NCOMMIT*XLEN  write data
//  cm_ready     out  1             FIFO can take NCOMMIT records this cycle
//  flush        in   1             empty FIFO; shadow file kept
//  out_valid    out  1             head record valid
//  out_ready    in   1             consumer accepts head
//  out_seq      out  32            record sequence number
//  out_pc/out_inst/out_wen/out_wdest/out_wdata  out  XLEN/32/1/AW/XLEN  head record fields
//  snap_gpr     out  NREGS*XLEN    shadow register file, entry i at [i*XLEN+:XLEN]
//  commit_cnt   out  64            total commits seen
//  overflow     out  1             sticky: commit arrived while cm_ready=0
//  hang         out  1             sticky watchdog flag
// BEHAVIOUR
//  - Reset: FIFO empty, out_valid=0, out_* fields 0, seq counter 0, snap_gpr all 0,
//    commit_cnt=0, overflow=0, hang=0, cm_ready=1. Reset mid-drain discards all records.
//  - cm_ready = (DEPTH - count) >= NCOMMIT, from registered count only; a pop in the
//    same cycle gives no credit.
//  - Push: valid channels enqueued in ascending channel order, packed without gaps.
//    Each record gets seq = seq counter + rank among that cycle's valid channels.
//    Seq counter advances by popcount(cm_valid); 32-bit wrap 0xFFFFFFFF -> 0.
//  - Pop: out_valid && out_ready removes head; head fields update next cycle (1-cycle read).
//    Push+pop in one cycle: count += pushes - 1.
//  - Shadow file: on cm_valid[i] && cm_wen[i], entry cm_wdest[i] <= cm_wdata[i] next edge.
//    Writes to index 0 or index >= NREGS are dropped (record still queued).
//    Same dest on two channels in one cycle: highest channel wins.
//  - commit_cnt += popcount(cm_valid) every cycle, independent of cm_ready and flush.
//  - Overflow: any cm_valid while cm_ready=0 sets overflow (sticky until reset).
//    That cycle's records are not queued and the seq counter does not advance.
//    Shadow file and commit_cnt still update.
//  - flush: next cycle count=0, out_valid=0. Flush wins over same-cycle push/pop:
//    those records are dropped, no overflow. The seq counter still advances.
//  - Pointers wrap modulo DEPTH; full = count==DEPTH, empty = count==0.
// CONFIGURATION
//  DIFFTEST_WATCHDOG_EN defined:
//    - idle counter clears on any cm_valid bit, else increments (saturating).
//    - When it reaches TIMEOUT, hang<=1 (sticky until reset).
//  DIFFTEST_WATCHDOG_EN undefined:
//    - no counter logic; hang tied 0; TIMEOUT unused.
// TESTING
//  - Reset then idle 10 cycles -> out_valid=0, cm_ready=1, commit_cnt=0, snap_gpr all 0.
//  - Commits ch0 (pc=0x80000000, wdest=5, wdata=0x11) and ch1 (pc=0x80000004, wdest=5,
//    wdata=0x22) in one cycle, out_ready=1 -> seq 0 then 1 in order; snap_gpr[5]=0x22;
//    commit_cnt=2.
//  - Write wdest=0, wdata=0xDEAD -> snap_gpr[0] stays 0; record still queued with wen=1.
//  - DEPTH=8, NCOMMIT=2, out_ready=0, both channels every cycle -> cm_ready=0 after 4 cycles.
//    A 5th-cycle commit sets overflow=1 and queues 8 records with seq 0..7. Then out_ready=1
//    drains 8 records, and cm_ready returns to 1 once count<=6.
//  - 3 records queued, flush with simultaneous ch0 commit -> next cycle out_valid=0; the next
//    commit gets seq 4 (seq counter advanced for the flushed commit); overflow=0.
//  - DIFFTEST_WATCHDOG_EN, TIMEOUT=16: no commits for 16 cycles -> hang=1 and stays 1
//    after a later commit. Without the macro -> hang=0 throughout.

Source files
------------

// File: rtl/difftest_commit_queue.sv
// difftest_commit_queue: commit monitor keeping a shadow register file and a sequence-numbered record FIFO.
// Optional no-commit watchdog is compiled in when DIFFTEST_WATCHDOG_EN is defined.
module difftest_commit_queue #(
    parameter int XLEN    = 64,
    parameter int NREGS   = 33,
    parameter int NCOMMIT = 2,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 4096,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [NCOMMIT-1:0]      cm_valid,
    input  logic [NCOMMIT*XLEN-1:0] cm_pc,
    input  logic [NCOMMIT*32-1:0]   cm_inst,
    input  logic [NCOMMIT-1:0]      cm_wen,
    input  logic [NCOMMIT*AW-1:0]   cm_wdest,
    input  logic [NCOMMIT*XLEN-1:0] cm_wdata,
    output logic                    cm_ready,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_seq,
    output logic [XLEN-1:0]         out_pc,
    output logic [31:0]             out_inst,
    output logic                    out_wen,
    output logic [AW-1:0]           out_wdest,
    output logic [XLEN-1:0]         out_wdata,
    output logic [NREGS*XLEN-1:0]   snap_gpr,
    output logic [63:0]             commit_cnt,
    output logic                    overflow,
    output logic                    hang
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int NW = $clog2(NCOMMIT + 1);

    typedef struct packed {
        logic [31:0]     seq;
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic            wen;
        logic [AW-1:0]   wdest;
        logic [XLEN-1:0] wdata;
    } rec_t;

    rec_t            mem [DEPTH];
    rec_t            head_q;
    rec_t            head_n;
    rec_t            ch_rec [NCOMMIT];
    logic [PW-1:0]   ch_slot [NCOMMIT];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_n;
    logic [PW-1:0]   rd_n;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_n;
    logic [NW-1:0]   n_valid;
    logic [31:0]     seq_cnt;
    logic [XLEN-1:0] gpr [NREGS];
    logic            any_valid;
    logic            accept;
    logic            pop;

    assign any_valid = |cm_valid;
    assign cm_ready  = int'(count) <= DEPTH - NCOMMIT;
    assign accept    = any_valid && cm_ready && !flush;
    assign pop       = out_valid && out_ready;

    // Rank each valid channel so records pack into consecutive slots with consecutive seq numbers.
    always_comb begin
        n_valid = '0;
        for (int i = 0; i < NCOMMIT; i++) begin
            ch_rec[i]  = '{seq:   seq_cnt + 32'(n_valid),
                           pc:    cm_pc[i*XLEN +: XLEN],
                           inst:  cm_inst[i*32 +: 32],
                           wen:   cm_wen[i],
                           wdest: cm_wdest[i*AW +: AW],
                           wdata: cm_wdata[i*XLEN +: XLEN]};
            ch_slot[i] = PW'((int'(wr_ptr) + int'(n_valid)) % DEPTH);
            n_valid    = n_valid + NW'(cm_valid[i]);
        end
    end

    // Head register is loaded with the next-state head, bypassing slots written this cycle.
    always_comb begin
        count_n = flush ? '0 : count + (accept ? CW'(n_valid) : '0) - CW'(pop);
        wr_n    = flush ? '0 : PW'((int'(wr_ptr) + (accept ? int'(n_valid) : 0)) % DEPTH);
        rd_n    = flush ? '0 : PW'((int'(rd_ptr) + int'(pop)) % DEPTH);
        head_n  = mem[rd_n];
        for (int i = 0; i < NCOMMIT; i++)
            if (accept && cm_valid[i] && ch_slot[i] == rd_n)
                head_n = ch_rec[i];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            seq_cnt    <= '0;
            out_valid  <= 1'b0;
            head_q     <= '0;
            commit_cnt <= '0;
            overflow   <= 1'b0;
        end else begin
            count      <= count_n;
            wr_ptr     <= wr_n;
            rd_ptr     <= rd_n;
            out_valid  <= count_n != '0;
            if (count_n != '0)
                head_q <= head_n;
            if (any_valid && (cm_ready || flush))
                seq_cnt <= seq_cnt + 32'(n_valid);
            commit_cnt <= commit_cnt + 64'(n_valid);
            if (any_valid && !cm_ready && !flush)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NCOMMIT; i++)
            if (accept && cm_valid[i])
                mem[ch_slot[i]] <= ch_rec[i];
    end

    // Ascending channel order makes the highest channel win on a shared destination.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NREGS; r++)
                gpr[r] <= '0;
        end else begin
            for (int i = 0; i < NCOMMIT; i++)
                if (cm_valid[i] && cm_wen[i] && cm_wdest[i*AW +: AW] != '0 && int'(cm_wdest[i*AW +: AW]) < NREGS)
                    gpr[cm_wdest[i*AW +: AW]] <= cm_wdata[i*XLEN +: XLEN];
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_snap
        assign snap_gpr[g*XLEN +: XLEN] = gpr[g];
    end

    assign out_seq   = head_q.seq;
    assign out_pc    = head_q.pc;
    assign out_inst  = head_q.inst;
    assign out_wen   = head_q.wen;
    assign out_wdest = head_q.wdest;
    assign out_wdata = head_q.wdata;

`ifdef DIFFTEST_WATCHDOG_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] idle_cnt;
    logic [TW-1:0] idle_n;
    logic          hang_q;

    assign idle_n = any_valid ? '0 : (idle_cnt == TW'(TIMEOUT) ? idle_cnt : idle_cnt + 1'b1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt <= '0;
            hang_q   <= 1'b0;
        end else begin
            idle_cnt <= idle_n;
            if (idle_n == TW'(TIMEOUT))
                hang_q <= 1'b1;
        end
    end

    assign hang = hang_q;
`else
    localparam int unused_timeout = TIMEOUT;
    assign hang = 1'b0;
`endif
endmodule

// File: tb/tb_difftest_commit_queue.sv
// tb_difftest_commit_queue: directed and randomized stimulus checked each cycle against a queue-based model.
module tb_difftest_commit_queue;
    localparam int XLEN    = 64;
    localparam int NREGS   = 33;
    localparam int NCOMMIT = 2;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;
    localparam int AW      = $clog2(NREGS);

    logic                    clock = 1'b0;
    logic                    reset_n = 1'b0;
    logic [NCOMMIT-1:0]      cm_valid = '0;
    logic [NCOMMIT*XLEN-1:0] cm_pc = '0;
    logic [NCOMMIT*32-1:0]   cm_inst = '0;
    logic [NCOMMIT-1:0]      cm_wen = '0;
    logic [NCOMMIT*AW-1:0]   cm_wdest = '0;
    logic [NCOMMIT*XLEN-1:0] cm_wdata = '0;
    logic                    cm_ready;
    logic                    flush = 1'b0;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic [31:0]             out_seq;
    logic [XLEN-1:0]         out_pc;
    logic [31:0]             out_inst;
    logic                    out_wen;
    logic [AW-1:0]           out_wdest;
    logic [XLEN-1:0]         out_wdata;
    logic [NREGS*XLEN-1:0]   snap_gpr;
    logic [63:0]             commit_cnt;
    logic                    overflow;
    logic                    hang;

    difftest_commit_queue #(.XLEN(XLEN), .NREGS(NREGS), .NCOMMIT(NCOMMIT), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset_n(reset_n), .cm_valid(cm_valid), .cm_pc(cm_pc), .cm_inst(cm_inst),
        .cm_wen(cm_wen), .cm_wdest(cm_wdest), .cm_wdata(cm_wdata), .cm_ready(cm_ready), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_seq(out_seq), .out_pc(out_pc), .out_inst(out_inst),
        .out_wen(out_wen), .out_wdest(out_wdest), .out_wdata(out_wdata), .snap_gpr(snap_gpr),
        .commit_cnt(commit_cnt), .overflow(overflow), .hang(hang)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0]     seq;
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic            wen;
        logic [AW-1:0]   wdest;
        logic [XLEN-1:0] wdata;
    } rec_t;

    rec_t            q[$];
    logic [XLEN-1:0] m_gpr [NREGS];
    logic [31:0]     m_seq;
    logic [63:0]     m_cnt;
    logic            m_ovf;
    logic            m_hang;
    int              m_idle;
    int              checks = 0;
    int              failures = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int r = 0; r < NREGS; r++)
            m_gpr[r] = '0;
        m_seq  = '0;
        m_cnt  = '0;
        m_ovf  = 1'b0;
        m_hang = 1'b0;
        m_idle = 0;
    endtask

    // Applies one clock edge worth of the commit-queue rules to the model.
    task automatic model_step();
        int   nv;
        int   rank;
        int   d;
        bit   rdy;
        bit   pop_now;
        rec_t r;
        nv = 0;
        for (int i = 0; i < NCOMMIT; i++)
            nv += int'(cm_valid[i]);
        rdy     = (DEPTH - q.size()) >= NCOMMIT;
        pop_now = q.size() != 0 && out_ready;
        m_cnt  += 64'(nv);
        for (int i = 0; i < NCOMMIT; i++)
            if (cm_valid[i] && cm_wen[i]) begin
                d = int'(cm_wdest[i*AW +: AW]);
                if (d != 0 && d < NREGS)
                    m_gpr[d] = cm_wdata[i*XLEN +: XLEN];
            end
        if (flush) begin
            q.delete();
            m_seq += 32'(nv);
        end else begin
            if (pop_now)
                void'(q.pop_front());
            if (nv > 0 && rdy) begin
                rank = 0;
                for (int i = 0; i < NCOMMIT; i++)
                    if (cm_valid[i]) begin
                        r.seq   = m_seq + 32'(rank);
                        r.pc    = cm_pc[i*XLEN +: XLEN];
                        r.inst  = cm_inst[i*32 +: 32];
                        r.wen   = cm_wen[i];
                        r.wdest = cm_wdest[i*AW +: AW];
                        r.wdata = cm_wdata[i*XLEN +: XLEN];
                        q.push_back(r);
                        rank++;
                    end
                m_seq += 32'(nv);
            end else if (nv > 0) begin
                m_ovf = 1'b1;
            end
        end
`ifdef DIFFTEST_WATCHDOG_EN
        if (nv > 0)
            m_idle = 0;
        else if (m_idle < TIMEOUT)
            m_idle++;
        if (m_idle == TIMEOUT)
            m_hang = 1'b1;
`endif
    endtask

    task automatic compare();
        bit bad;
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        chk("cm_ready", 64'(cm_ready), 64'((DEPTH - q.size()) >= NCOMMIT));
        if (q.size() != 0) begin
            chk("out_seq", 64'(out_seq), 64'(q[0].seq));
            chk("out_pc", out_pc, q[0].pc);
            chk("out_inst", 64'(out_inst), 64'(q[0].inst));
            chk("out_wen", 64'(out_wen), 64'(q[0].wen));
            chk("out_wdest", 64'(out_wdest), 64'(q[0].wdest));
            chk("out_wdata", out_wdata, q[0].wdata);
        end
        chk("commit_cnt", commit_cnt, m_cnt);
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("hang", 64'(hang), 64'(m_hang));
        checks++;
        bad = 0;
        for (int r = 0; r < NREGS; r++)
            if (!bad && snap_gpr[r*XLEN +: XLEN] !== m_gpr[r]) begin
                bad = 1;
                $display("FAIL snap_gpr[%0d] got=%0h exp=%0h", r, snap_gpr[r*XLEN +: XLEN], m_gpr[r]);
            end
        if (bad)
            failures++;
    endtask

    task automatic step();
        @(posedge clock);
        model_step();
        @(negedge clock);
        compare();
    endtask

    task automatic clear_in();
        cm_valid  = '0;
        cm_pc     = '0;
        cm_inst   = '0;
        cm_wen    = '0;
        cm_wdest  = '0;
        cm_wdata  = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic set_ch(input int i, input logic [63:0] pc, input logic [AW-1:0] dest, input logic [63:0] data);
        cm_valid[i]              = 1'b1;
        cm_pc[i*XLEN +: XLEN]    = pc;
        cm_inst[i*32 +: 32]      = 32'h0000_0013 + 32'(i);
        cm_wen[i]                = 1'b1;
        cm_wdest[i*AW +: AW]     = dest;
        cm_wdata[i*XLEN +: XLEN] = data;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_in();
        model_reset();
        #3;
        compare();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        do_reset();
        for (int c = 0; c < 10; c++)
            step();
        chk("idle_out_valid", 64'(out_valid), 64'h0);
        chk("idle_cm_ready", 64'(cm_ready), 64'h1);
        chk("idle_commit_cnt", commit_cnt, 64'h0);

        out_ready = 1'b1;
        set_ch(0, 64'h8000_0000, AW'(5), 64'h11);
        set_ch(1, 64'h8000_0004, AW'(5), 64'h22);
        step();
        chk("pair_first_seq", 64'(out_seq), 64'h0);
        cm_valid = '0;
        step();
        chk("pair_second_seq", 64'(out_seq), 64'h1);
        chk("pair_gpr5", snap_gpr[5*XLEN +: XLEN], 64'h22);
        chk("pair_commit_cnt", commit_cnt, 64'h2);
        step();

        set_ch(0, 64'h8000_0008, AW'(0), 64'hDEAD);
        step();
        cm_valid = '0;
        chk("x0_seq", 64'(out_seq), 64'h2);
        chk("x0_wen", 64'(out_wen), 64'h1);
        chk("x0_wdata", out_wdata, 64'hDEAD);
        chk("x0_gpr0", snap_gpr[XLEN-1:0], 64'h0);
        step();

        do_reset();
        for (int c = 0; c < 4; c++) begin
            set_ch(0, 64'h1000 + 64'(c * 8), AW'(c + 1), 64'(c));
            set_ch(1, 64'h1004 + 64'(c * 8), AW'(c + 10), 64'(c + 100));
            step();
        end
        chk("full_cm_ready", 64'(cm_ready), 64'h0);
        step();
        chk("full_overflow", 64'(overflow), 64'h1);
        chk("full_head_seq", 64'(out_seq), 64'h0);
        cm_valid  = '0;
        out_ready = 1'b1;
        for (int k = 1; k < 8; k++) begin
            step();
            chk("drain_seq", 64'(out_seq), 64'(k));
        end
        step();
        chk("drain_empty", 64'(out_valid), 64'h0);

        do_reset();
        for (int c = 0; c < 3; c++) begin
            set_ch(0, 64'h2000 + 64'(c * 4), AW'(7), 64'(c));
            step();
        end
        flush = 1'b1;
        step();
        chk("flush_out_valid", 64'(out_valid), 64'h0);
        chk("flush_overflow", 64'(overflow), 64'h0);
        flush = 1'b0;
        step();
        chk("flush_next_seq", 64'(out_seq), 64'h4);

        clear_in();
        for (int c = 0; c < 20; c++)
            step();
`ifdef DIFFTEST_WATCHDOG_EN
        chk("hang_set", 64'(hang), 64'h1);
`else
        chk("hang_tied", 64'(hang), 64'h0);
`endif
        set_ch(0, 64'h3000, AW'(3), 64'h33);
        step();
        clear_in();

        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NCOMMIT; i++) begin
                cm_valid[i]              = $urandom_range(0, 2) != 0;
                cm_pc[i*XLEN +: XLEN]    = {$urandom, $urandom};
                cm_inst[i*32 +: 32]      = $urandom;
                cm_wen[i]                = $urandom_range(0, 3) != 0;
                cm_wdest[i*AW +: AW]     = AW'($urandom_range(0, 63));
                cm_wdata[i*XLEN +: XLEN] = {$urandom, $urandom};
            end
            if (($urandom_range(0, 15)) == 0)
                cm_valid = '0;
            out_ready = $urandom_range(0, 3) < ((c / 250) % 2 == 0 ? 3 : 1);
            flush     = $urandom_range(0, 63) == 0;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
